ccip_tx_shim: RTL and testbench
===============================

# ccip_tx_shim

Transmit-side buffer between AFU request logic and the CCI-P Tx port. It holds c0 (read) and c1 (write) requests in per-channel FIFOs and releases them only while the matching CCI-P almost-full flag is low. Every Tx output is registered, as the PR-region boundary requires. MMIO read responses (c2) pass through with one register stage and are never stalled. The block sits directly in front of `pck_af2cp_sTx` in `ccip_std_afu`.

## Interface
Parameters:
- `DEPTH_LOG2`, default 3: log2 of per-channel FIFO depth (8 entries).

Ports (name, direction, width, meaning):
- `pClk` in 1: CCI-P primary clock; the only clock in the block.
- `pck_cp2af_softReset` in 1: reset, synchronous, active-high.
- `c0_req_hdr` in 74: read request header.
- `c0_req_valid` in 1: read request valid.
- `c0_req_ready` out 1: c0 FIFO not full.
- `c1_req_hdr` in 80: write request header.
- `c1_req_data` in 512: write data.
- `c1_req_valid` in 1: write request valid.
- `c1_req_ready` out 1: c1 FIFO not full.
- `c2_rsp_hdr` in 9: MMIO read response header (tid).
- `c2_rsp_data` in 64: MMIO read response data.
- `c2_rsp_valid` in 1: MMIO read response valid.
- `c0TxAlmFull` in 1: CCI-P c0 almost-full flag.
- `c1TxAlmFull` in 1: CCI-P c1 almost-full flag.
- `tx_c0_hdr` out 74, `tx_c0_valid` out 1: CCI-P c0 Tx.
- `tx_c1_hdr` out 80, `tx_c1_data` out 512, `tx_c1_valid` out 1: CCI-P c1 Tx.
- `tx_c2_hdr` out 9, `tx_c2_data` out 64, `tx_c2_mmioRdValid` out 1: CCI-P c2 Tx.
- `c0_count` out DEPTH_LOG2+1: c0 FIFO occupancy.
- `c1_count` out DEPTH_LOG2+1: c1 FIFO occupancy.
- `c0_stall_cnt` out 32: c0 stall-cycle counter (see Configuration).
- `c1_stall_cnt` out 32: c1 stall-cycle counter (see Configuration).

## Operation
- Channels c0 and c1 behave identically and independently; each has a FIFO of 2^DEPTH_LOG2 entries with read/write pointers of DEPTH_LOG2 bits that wrap naturally.
- Push occurs when `cX_req_valid && cX_req_ready`.
- `cX_req_ready = (cX_count != 2^DEPTH_LOG2)`, driven combinationally from the count register.
- When full, ready is 0 even if a pop happens in the same cycle. There is no full-time bypass.
- Pop occurs when `cX_count != 0 && !cXTxAlmFull`. On a pop, the head entry is loaded into the `tx_cX_*` registers and `tx_cX_valid` is set to 1 for one cycle. Otherwise `tx_cX_valid` is 0 and hdr/data hold their previous values.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- Push into an empty FIFO is not bypassed. The entry must be written before it can be popped.
- c2 path: `tx_c2_* <= c2_rsp_*` every cycle. It is never stalled and ignores both almost-full flags.
- FIFO order is strict. There is no reordering within a channel and no arbitration between channels.

## Timing
- Reset: pointers, counts and stall counters are cleared to 0. All `tx_*` valid, hdr and data registers are cleared to 0. `cX_req_ready` reads 1 in the first cycle after reset.
- Reset asserted mid-operation: from the next edge, all queued entries are discarded and no `tx_*_valid` is asserted while reset is high.
- c0/c1 latency: a push at edge N with an empty FIFO and almost-full low gives `tx_cX_valid` = 1 during cycle N+2, i.e. 2 cycles.
- c2 latency: 1 cycle.
- Almost-full is sampled on the same edge as the pop decision. Almost-full rising at edge N means no pop at edge N. The downstream slack (≥8 entries) covers the in-flight register.
- Sustained throughput with almost-full low: 1 entry per cycle per channel.

## Configuration
- `CCIP_TX_SHIM_STATS_EN` defined:
  - `cX_stall_cnt` increments on every cycle where `cX_count != 0 && cXTxAlmFull`.
  - The counters saturate at 0xFFFFFFFF and clear on reset.
- `CCIP_TX_SHIM_STATS_EN` undefined:
  - Both stall counters are tied to 0.
  - No counter logic is synthesized.

## Test plan
- Single c0 request, hdr 0x155, almost-full low, pushed at edge 10 -> `tx_c0_valid` high for exactly one cycle at cycle 12 with hdr 0x155; `c0_count` returns to 0.
- Hold `c1TxAlmFull` = 1 and push 9 writes with data 0..8 -> 8 accepted, `c1_req_ready` = 0 after the 8th, `c1_count` = 8. Release almost-full -> 8 consecutive valids carrying data 0..7 in order.
- Continuous push/pop for 20 cycles at DEPTH_LOG2 = 3 -> pointer wrap is exercised, order is preserved, `c0_count` stays at 1, no bubbles.
- `c0TxAlmFull` = 1 with `c1TxAlmFull` = 0 and both FIFOs holding 3 entries -> c1 drains in 3 cycles, c0 emits nothing; with STATS_EN, `c0_stall_cnt` = 3 after 3 cycles.
- Assert `c2_rsp_valid` with tid 0x1A and data 0xDEADBEEF while both almost-full flags are 1 -> `tx_c2_mmioRdValid` goes high 1 cycle later with matching hdr and data.
- Assert reset while c1 holds 5 entries -> no `tx_c1_valid` during or after reset, `c1_count` = 0, `c1_req_ready` = 1.

Source files
------------

// File: rtl/ccip_tx_shim.sv
// CCI-P Tx buffer: per-channel c0/c1 FIFOs gated by almost-full, registered c2.
// Optional stall counters under CCIP_TX_SHIM_STATS_EN.

module ccip_tx_chan_stage #(
    parameter int W          = 74,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  pClk,
    input  logic                  reset,
    input  logic [W-1:0]          reqHdr,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  almFull,
    output logic [W-1:0]          txHdr,
    output logic                  txValid,
    output logic [DEPTH_LOG2:0]   count,
    output logic [31:0]           stallCnt
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wrPtr;
    logic [DEPTH_LOG2-1:0]   rdPtr;
    logic                    push;
    logic                    pop;

    // Ready comes from the registered count only; a same-cycle pop never frees a slot.
    assign reqReady = (count != FULL);
    assign push     = reqValid && reqReady;
    assign pop      = (count != '0) && !almFull;

    always_ff @(posedge pClk) begin
        if (push) begin
            mem[wrPtr] <= reqHdr;
        end
    end

    always_ff @(posedge pClk) begin
        if (reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            txValid <= 1'b0;
            txHdr   <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
                txHdr <= mem[rdPtr];
            end
            txValid <= pop;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef CCIP_TX_SHIM_STATS_EN
    logic [31:0] stallQ;

    always_ff @(posedge pClk) begin
        if (reset) begin
            stallQ <= '0;
        end else if ((count != '0) && almFull && (stallQ != '1)) begin
            stallQ <= stallQ + 32'd1;
        end
    end

    assign stallCnt = stallQ;
`else
    assign stallCnt = '0;
`endif

endmodule

module ccip_tx_shim #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  pClk,
    input  logic                  pck_cp2af_softReset,
    input  logic [73:0]           c0_req_hdr,
    input  logic                  c0_req_valid,
    output logic                  c0_req_ready,
    input  logic [79:0]           c1_req_hdr,
    input  logic [511:0]          c1_req_data,
    input  logic                  c1_req_valid,
    output logic                  c1_req_ready,
    input  logic [8:0]            c2_rsp_hdr,
    input  logic [63:0]           c2_rsp_data,
    input  logic                  c2_rsp_valid,
    input  logic                  c0TxAlmFull,
    input  logic                  c1TxAlmFull,
    output logic [73:0]           tx_c0_hdr,
    output logic                  tx_c0_valid,
    output logic [79:0]           tx_c1_hdr,
    output logic [511:0]          tx_c1_data,
    output logic                  tx_c1_valid,
    output logic [8:0]            tx_c2_hdr,
    output logic [63:0]           tx_c2_data,
    output logic                  tx_c2_mmioRdValid,
    output logic [DEPTH_LOG2:0]   c0_count,
    output logic [DEPTH_LOG2:0]   c1_count,
    output logic [31:0]           c0_stall_cnt,
    output logic [31:0]           c1_stall_cnt
);

    logic [591:0] c1Tx;

    ccip_tx_chan_stage #(
        .W          (74),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_c0 (
        .pClk     (pClk),
        .reset    (pck_cp2af_softReset),
        .reqHdr   (c0_req_hdr),
        .reqValid (c0_req_valid),
        .reqReady (c0_req_ready),
        .almFull  (c0TxAlmFull),
        .txHdr    (tx_c0_hdr),
        .txValid  (tx_c0_valid),
        .count    (c0_count),
        .stallCnt (c0_stall_cnt)
    );

    // Write header and data travel as one FIFO word.
    ccip_tx_chan_stage #(
        .W          (592),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_c1 (
        .pClk     (pClk),
        .reset    (pck_cp2af_softReset),
        .reqHdr   ({c1_req_hdr, c1_req_data}),
        .reqValid (c1_req_valid),
        .reqReady (c1_req_ready),
        .almFull  (c1TxAlmFull),
        .txHdr    (c1Tx),
        .txValid  (tx_c1_valid),
        .count    (c1_count),
        .stallCnt (c1_stall_cnt)
    );

    assign tx_c1_hdr  = c1Tx[591:512];
    assign tx_c1_data = c1Tx[511:0];

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            tx_c2_hdr         <= '0;
            tx_c2_data        <= '0;
            tx_c2_mmioRdValid <= 1'b0;
        end else begin
            tx_c2_hdr         <= c2_rsp_hdr;
            tx_c2_data        <= c2_rsp_data;
            tx_c2_mmioRdValid <= c2_rsp_valid;
        end
    end

endmodule

// File: tb/tb_ccip_tx_shim.sv
// Directed self-checking bench for ccip_tx_shim (DEPTH_LOG2 = 3).
// Stall-counter expectations follow CCIP_TX_SHIM_STATS_EN.

module tb_ccip_tx_shim;

    logic          pClk = 1'b0;
    logic          rst;
    logic [73:0]   c0Hdr;
    logic          c0Valid;
    logic          c0Ready;
    logic [79:0]   c1Hdr;
    logic [511:0]  c1Data;
    logic          c1Valid;
    logic          c1Ready;
    logic [8:0]    c2Hdr;
    logic [63:0]   c2Data;
    logic          c2Valid;
    logic          c0Af;
    logic          c1Af;
    logic [73:0]   txC0Hdr;
    logic          txC0Valid;
    logic [79:0]   txC1Hdr;
    logic [511:0]  txC1Data;
    logic          txC1Valid;
    logic [8:0]    txC2Hdr;
    logic [63:0]   txC2Data;
    logic          txC2Valid;
    logic [3:0]    c0Count;
    logic [3:0]    c1Count;
    logic [31:0]   c0Stall;
    logic [31:0]   c1Stall;

    int total = 0;
    int bad   = 0;

`ifdef CCIP_TX_SHIM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 pClk = ~pClk;

    ccip_tx_shim #(.DEPTH_LOG2(3)) dut (
        .pClk                (pClk),
        .pck_cp2af_softReset (rst),
        .c0_req_hdr          (c0Hdr),
        .c0_req_valid        (c0Valid),
        .c0_req_ready        (c0Ready),
        .c1_req_hdr          (c1Hdr),
        .c1_req_data         (c1Data),
        .c1_req_valid        (c1Valid),
        .c1_req_ready        (c1Ready),
        .c2_rsp_hdr          (c2Hdr),
        .c2_rsp_data         (c2Data),
        .c2_rsp_valid        (c2Valid),
        .c0TxAlmFull         (c0Af),
        .c1TxAlmFull         (c1Af),
        .tx_c0_hdr           (txC0Hdr),
        .tx_c0_valid         (txC0Valid),
        .tx_c1_hdr           (txC1Hdr),
        .tx_c1_data          (txC1Data),
        .tx_c1_valid         (txC1Valid),
        .tx_c2_hdr           (txC2Hdr),
        .tx_c2_data          (txC2Data),
        .tx_c2_mmioRdValid   (txC2Valid),
        .c0_count            (c0Count),
        .c1_count            (c1Count),
        .c0_stall_cnt        (c0Stall),
        .c1_stall_cnt        (c1Stall)
    );

    task automatic chk(input string tag, input logic [591:0] obs,
                       input logic [591:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    function automatic logic [31:0] st(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst = 1'b1;
        c0Hdr = '0; c0Valid = 1'b0;
        c1Hdr = '0; c1Data = '0; c1Valid = 1'b0;
        c2Hdr = '0; c2Data = '0; c2Valid = 1'b0;
        c0Af = 1'b0; c1Af = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_c0_count", c0Count, 0);
        chk("rst_c1_count", c1Count, 0);
        chk("rst_c0_ready", c0Ready, 1);
        chk("rst_c1_ready", c1Ready, 1);
        chk("rst_c0_valid", txC0Valid, 0);
        chk("rst_c1_valid", txC1Valid, 0);
        chk("rst_c2_valid", txC2Valid, 0);
        chk("rst_c0_hdr", txC0Hdr, 0);
        chk("rst_c1_data", txC1Data, 0);
        chk("rst_c0_stall", c0Stall, 0);

        // single c0 request: 2-cycle latency, one-cycle valid
        c0Hdr = 74'h155; c0Valid = 1'b1;
        tick();
        c0Valid = 1'b0;
        chk("single_count1", c0Count, 1);
        chk("single_early", txC0Valid, 0);
        tick();
        chk("single_valid", txC0Valid, 1);
        chk("single_hdr", txC0Hdr, 74'h155);
        chk("single_count0", c0Count, 0);
        tick();
        chk("single_pulse", txC0Valid, 0);
        chk("single_hold", txC0Hdr, 74'h155);

        // c1 fill under almost-full: 8 accepted, 9th refused
        c1Af = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c1Hdr = 80'(i + 16'h100); c1Data = 512'(i); c1Valid = 1'b1;
            tick();
            chk("fill_novalid", txC1Valid, 0);
        end
        chk("fill_count8", c1Count, 8);
        chk("fill_ready0", c1Ready, 0);
        c1Hdr = 80'h108; c1Data = 512'd8;
        tick();
        c1Valid = 1'b0;
        chk("fill_9th_count", c1Count, 8);
        chk("fill_stall", c1Stall, st(8));
        c1Af = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_valid", txC1Valid, 1);
            chk("drain_data", txC1Data, 512'(i));
            chk("drain_hdr", txC1Hdr, 80'(i + 16'h100));
        end
        tick();
        chk("drain_end_valid", txC1Valid, 0);
        chk("drain_end_count", c1Count, 0);
        chk("drain_end_ready", c1Ready, 1);
        chk("drain_end_stall", c1Stall, st(8));

        // back-to-back push/pop through pointer wrap
        for (int i = 0; i < 20; i++) begin
            c0Hdr = 74'(16'h200 + i); c0Valid = 1'b1;
            tick();
            chk("stream_count", c0Count, 1);
            if (i > 0) begin
                chk("stream_valid", txC0Valid, 1);
                chk("stream_hdr", txC0Hdr, 74'(16'h200 + i - 1));
            end
        end
        c0Valid = 1'b0;
        tick();
        chk("stream_last_valid", txC0Valid, 1);
        chk("stream_last_hdr", txC0Hdr, 74'h213);
        chk("stream_last_count", c0Count, 0);
        tick();
        chk("stream_idle", txC0Valid, 0);

        // c0 blocked while c1 drains 3 entries
        c0Af = 1'b1; c1Af = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c0Hdr = 74'(16'h300 + i); c0Valid = 1'b1;
            c1Hdr = 80'(16'h40 + i); c1Data = 512'(16'h40 + i); c1Valid = 1'b1;
            tick();
        end
        c0Valid = 1'b0; c1Valid = 1'b0;
        chk("ind_c0_count", c0Count, 3);
        chk("ind_c1_count", c1Count, 3);
        c1Af = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ind_c1_valid", txC1Valid, 1);
            chk("ind_c1_data", txC1Data, 512'(16'h40 + i));
            chk("ind_c0_blocked", txC0Valid, 0);
        end
        // 2 stall cycles during the fill plus 3 during the drain
        chk("ind_c0_stall", c0Stall, st(5));
        chk("ind_c1_stall", c1Stall, st(10));
        tick();
        chk("ind_c1_done", txC1Valid, 0);
        chk("ind_c1_empty", c1Count, 0);
        chk("ind_c0_still3", c0Count, 3);

        // c2 ignores almost-full
        c1Af = 1'b1;
        c2Hdr = 9'h1A; c2Data = 64'hDEADBEEF; c2Valid = 1'b1;
        tick();
        c2Valid = 1'b0;
        chk("c2_valid", txC2Valid, 1);
        chk("c2_hdr", txC2Hdr, 9'h1A);
        chk("c2_data", txC2Data, 64'hDEADBEEF);
        tick();
        chk("c2_pulse", txC2Valid, 0);

        // reset with c1 holding 5 entries
        for (int i = 0; i < 5; i++) begin
            c1Hdr = 80'(16'h50 + i); c1Data = 512'(i); c1Valid = 1'b1;
            tick();
        end
        c1Valid = 1'b0;
        chk("rst5_count", c1Count, 5);
        c1Af = 1'b0; c0Af = 1'b0; rst = 1'b1;
        tick();
        chk("rst5_valid_a", txC1Valid, 0);
        chk("rst5_count0", c1Count, 0);
        tick();
        chk("rst5_valid_b", txC1Valid, 0);
        chk("rst5_c0_valid", txC0Valid, 0);
        rst = 1'b0;
        tick();
        chk("rst5_after_valid", txC1Valid, 0);
        chk("rst5_after_count", c1Count, 0);
        chk("rst5_after_ready", c1Ready, 1);
        chk("rst5_c0_count", c0Count, 0);
        chk("rst5_stall", c0Stall, 0);
        tick();
        chk("rst5_quiet", txC1Valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
